// File: rtl/gshare_sat_predictor.sv
// gshare_sat_predictor: N-lane gshare direction predictor with 2-bit counters and a direct-mapped BTB
module gshare_sat_predictor #(
  parameter int N = 2,
  parameter int HIST_W = 8,
  parameter int BTB_IDX_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           pc_start,
  input  logic                  fetch_valid,
  input  logic                  fetch_stall,
  input  logic                  flush,
  output logic [N-1:0]          pred_valid,
  output logic [N-1:0]          pred_taken,
  output logic [N*32-1:0]       pred_next_pc,
  output logic [N*HIST_W-1:0]   pred_hist,
  input  logic [N-1:0]          commit_valid,
  input  logic [N-1:0]          commit_cond,
  input  logic [N*32-1:0]       commit_pc,
  input  logic [N-1:0]          commit_taken,
  input  logic [N*32-1:0]       commit_target,
  input  logic [N*HIST_W-1:0]   commit_hist,
  input  logic [N-1:0]          commit_mispred,
  output logic [HIST_W-1:0]     spec_hist,
  output logic [31:0]           mispred_count
);
  localparam int PHT_N = 1 << HIST_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;
  logic [1:0]        pht [PHT_N];
  logic              btb_v [BTB_N];
  logic [TAG_W-1:0]  btb_tag [BTB_N];
  logic [31:0]       btb_tgt [BTB_N];
  logic [HIST_W-1:0] arch_hist, arch_next, hist_acc;
  logic [HIST_W-1:0] cidx [N];
  logic [1:0]        cnt_new [N];
  logic [32:0]       mis_sum;
  logic [N-1:0]      upd, wr;
  assign upd = commit_valid & commit_cond;
  assign wr  = commit_valid & commit_taken;
  // per-lane prediction; each BTB hit ahead of a lane ages that lane's history by one bit
  always_comb begin
    logic [31:0]          pc;
    logic [HIST_W-1:0]    h, pi;
    logic [BTB_IDX_W-1:0] bi;
    logic                 hit, tk, stop;
    h = spec_hist;
    hist_acc = spec_hist;
    stop = 1'b0;
    pc = '0;
    pi = '0;
    bi = '0;
    hit = 1'b0;
    tk = 1'b0;
    pred_valid = '0;
    pred_taken = '0;
    pred_next_pc = '0;
    pred_hist = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc_start + 32'(4 * i);
      bi = pc[BTB_IDX_W+1:2];
      hit = btb_v[bi] && btb_tag[bi] == pc[31:BTB_IDX_W+2];
      pi = pc[HIST_W+1:2] ^ h;
      tk = hit && pht[pi][1];
      pred_taken[i] = tk;
      pred_valid[i] = fetch_valid && !stop;
      pred_next_pc[i*32 +: 32] = tk ? btb_tgt[bi] : pc + 32'd4;
      pred_hist[i*HIST_W +: HIST_W] = h;
      hist_acc = hit && !stop ? {hist_acc[HIST_W-2:0], tk} : hist_acc;
      h = hit ? h << 1 : h;
      stop = stop | tk;
    end
  end
  // commit-side next state: architectural history, cumulative counter values, mispredict sum
  always_comb begin
    logic [1:0] c;
    c = '0;
    arch_next = arch_hist;
    mis_sum = {1'b0, mispred_count};
    for (int i = 0; i < N; i++) begin
      cidx[i] = commit_pc[i*32+2 +: HIST_W] ^ commit_hist[i*HIST_W +: HIST_W];
      arch_next = upd[i] ? {arch_next[HIST_W-2:0], commit_taken[i]} : arch_next;
      mis_sum = mis_sum + 33'(commit_valid[i] & commit_mispred[i]);
    end
    for (int i = 0; i < N; i++) begin
      c = pht[cidx[i]];
      for (int j = 0; j <= i; j++)
        if (upd[j] && cidx[j] == cidx[i])
          c = commit_taken[j] ? (c == 2'd3 ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
      cnt_new[i] = c;
    end
  end
  // table and history registers; later lanes overwrite earlier ones on collisions
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < PHT_N; e++) pht[e] <= 2'b01;
      for (int e = 0; e < BTB_N; e++) btb_v[e] <= 1'b0;
      spec_hist <= '0;
      arch_hist <= '0;
      mispred_count <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (upd[i]) pht[cidx[i]] <= cnt_new[i];
        if (wr[i]) begin
          btb_v[commit_pc[i*32+2 +: BTB_IDX_W]] <= 1'b1;
          btb_tag[commit_pc[i*32+2 +: BTB_IDX_W]] <= commit_pc[i*32+BTB_IDX_W+2 +: TAG_W];
          btb_tgt[commit_pc[i*32+2 +: BTB_IDX_W]] <= commit_target[i*32 +: 32];
        end
      end
      arch_hist <= arch_next;
      spec_hist <= flush ? arch_next : (fetch_valid && !fetch_stall) ? hist_acc : spec_hist;
      mispred_count <= mis_sum[32] ? '1 : mis_sum[31:0];
    end
  end
endmodule

// File: tb/tb_gshare_sat_predictor.sv
// tb_gshare_sat_predictor: scoreboard bench against a table-level reference model
module tb_gshare_sat_predictor;
  localparam int N = 2, HW = 8, BI = 4;
  logic clock, reset, fetch_valid, fetch_stall, flush;
  logic [31:0] pc_start;
  logic [N-1:0] pred_valid, pred_taken, commit_valid, commit_cond, commit_taken, commit_mispred;
  logic [N*32-1:0] pred_next_pc, commit_pc, commit_target;
  logic [N*HW-1:0] pred_hist, commit_hist;
  logic [HW-1:0] spec_hist;
  logic [31:0] mispred_count;

  gshare_sat_predictor #(.N(N), .HIST_W(HW), .BTB_IDX_W(BI)) dut (
    .clock(clock), .reset(reset), .pc_start(pc_start), .fetch_valid(fetch_valid),
    .fetch_stall(fetch_stall), .flush(flush), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc), .pred_hist(pred_hist), .commit_valid(commit_valid),
    .commit_cond(commit_cond), .commit_pc(commit_pc), .commit_taken(commit_taken),
    .commit_target(commit_target), .commit_hist(commit_hist), .commit_mispred(commit_mispred),
    .spec_hist(spec_hist), .mispred_count(mispred_count));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [N-1:0] v, t;
    logic [N*32-1:0] npc;
    logic [N*HW-1:0] ph;
    logic [HW-1:0] sh;
    logic [31:0] mc;
    logic fv;
  } exp_t;
  exp_t q[$];

  int pht[256];
  bit bv[16];
  int unsigned btag[16], btgt[16];
  int unsigned spec, arch;
  longint mcnt;
  int vec = 0, errs = 0, ncmp = 0;
  int unsigned pool[6] = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h1100, 32'h40};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_model();
    foreach (pht[e]) pht[e] = 1;
    foreach (bv[e]) bv[e] = 0;
    spec = 0;
    arch = 0;
    mcnt = 0;
  endtask

  task automatic clr();
    reset = 0; fetch_valid = 0; fetch_stall = 0; flush = 0; pc_start = 0;
    commit_valid = 0; commit_cond = 0; commit_taken = 0; commit_mispred = 0;
    commit_pc = 0; commit_target = 0; commit_hist = 0;
  endtask

  task automatic com(int l, logic [31:0] pc, logic c, logic t, logic [31:0] tg, logic [7:0] h, logic m);
    commit_valid[l] = 1; commit_cond[l] = c; commit_taken[l] = t; commit_mispred[l] = m;
    commit_pc[l*32 +: 32] = pc; commit_target[l*32 +: 32] = tg; commit_hist[l*HW +: HW] = h;
  endtask

  // predict from current model state, queue expectation, then advance model and clock
  task automatic step();
    exp_t e;
    int unsigned pc, h, idx, bi, sp, cpc;
    int k;
    bit stop, hit, tk;
    e.sh = HW'(spec); e.mc = 32'(mcnt); e.fv = fetch_valid;
    e.v = 0; e.t = 0; e.npc = 0; e.ph = 0;
    k = 0; stop = 0; sp = spec;
    for (int i = 0; i < N; i++) begin
      pc = pc_start + 4 * i;
      bi = (pc >> 2) % 16;
      hit = bv[bi] && btag[bi] == (pc >> 6);
      h = (spec << k) & 255;
      idx = ((pc >> 2) ^ h) & 255;
      tk = hit && pht[idx] >= 2;
      e.t[i] = tk;
      e.npc[i*32 +: 32] = tk ? btgt[bi] : pc + 4;
      e.ph[i*HW +: HW] = HW'(h);
      e.v[i] = fetch_valid && !stop;
      if (hit && !stop) sp = ((sp << 1) | tk) & 255;
      if (hit) k++;
      if (tk) stop = 1;
    end
    q.push_back(e);
    vec++;
    for (int i = 0; i < N; i++) begin
      cpc = commit_pc[i*32 +: 32];
      if (commit_valid[i] && commit_cond[i]) begin
        arch = ((arch << 1) | commit_taken[i]) & 255;
        idx = ((cpc >> 2) ^ commit_hist[i*HW +: HW]) & 255;
        pht[idx] = commit_taken[i] ? (pht[idx] < 3 ? pht[idx] + 1 : 3) : (pht[idx] > 0 ? pht[idx] - 1 : 0);
      end
      if (commit_valid[i] && commit_taken[i]) begin
        bi = (cpc >> 2) % 16;
        bv[bi] = 1; btag[bi] = cpc >> 6; btgt[bi] = commit_target[i*32 +: 32];
      end
      if (commit_valid[i] && commit_mispred[i]) mcnt++;
    end
    if (mcnt > 64'hFFFF_FFFF) mcnt = 64'hFFFF_FFFF;
    if (flush) spec = arch;
    else if (fetch_valid && !fetch_stall) spec = sp;
    if (reset) init_model();
    @(posedge clock);
    #1;
  endtask

  // monitor: compare each presented cycle against the queued expectation
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pred_valid", 64'(pred_valid), 64'(e.v));
      if (e.fv) begin
        chk("pred_taken", 64'(pred_taken), 64'(e.t));
        chk("pred_next_pc", 64'(pred_next_pc), 64'(e.npc));
        chk("pred_hist", 64'(pred_hist), 64'(e.ph));
      end
      chk("spec_hist", 64'(spec_hist), 64'(e.sh));
      chk("mispred_count", 64'(mispred_count), 64'(e.mc));
    end
  end

  initial begin
    bit [7:0] pat;
    clr();
    reset = 1;
    @(posedge clock);
    #1;
    init_model();
    // reset predictions
    clr(); fetch_valid = 1; pc_start = 32'h100; #1;
    chk("req022_npc", 64'(pred_next_pc), {32'h0, 32'h108, 32'h104});
    chk("req022_valid", 64'(pred_valid), 64'h3);
    chk("req022_taken", 64'(pred_taken), 64'h0);
    step();
    // training
    clr(); reset = 1; step();
    repeat (2) begin clr(); com(0, 32'h100, 1, 1, 32'h200, 0, 0); step(); end
    clr(); fetch_valid = 1; pc_start = 32'h100; #1;
    chk("req023_npc0", 64'(pred_next_pc[31:0]), 64'h200);
    chk("req023_valid", 64'(pred_valid), 64'h1);
    step();
    chk("req023_hist", 64'(spec_hist), 64'h1);
    // saturation
    clr(); reset = 1; step();
    repeat (5) begin clr(); com(0, 32'h180, 1, 0, 32'h280, 0, 0); step(); end
    clr(); fetch_valid = 1; pc_start = 32'h180; step();
    repeat (5) begin clr(); com(0, 32'h180, 1, 1, 32'h280, 0, 0); step(); end
    clr(); fetch_valid = 1; fetch_stall = 1; pc_start = 32'h180; #1;
    chk("req024_taken", 64'(pred_taken[0]), 64'h1);
    step();
    clr(); com(0, 32'h180, 1, 0, 32'h280, 0, 0); step();
    clr(); fetch_valid = 1; fetch_stall = 1; pc_start = 32'h180; step();
    // same-index lanes
    clr(); reset = 1; step();
    clr(); com(0, 32'h40, 1, 1, 32'h500, 0, 0); com(1, 32'h40, 1, 1, 32'h600, 0, 0); step();
    clr(); fetch_valid = 1; fetch_stall = 1; pc_start = 32'h40; #1;
    chk("req025_npc0", 64'(pred_next_pc[31:0]), 64'h600);
    step();
    clr(); com(0, 32'h40, 1, 0, 0, 0, 0); step();
    clr(); fetch_valid = 1; pc_start = 32'h40; step();
    // flush restores committed history
    clr(); reset = 1; step();
    pat = 8'hAB;
    for (int b = 7; b >= 0; b--) begin clr(); com(0, 32'h300, 1, pat[b], 32'h400, 0, 0); flush = (b == 0); step(); end
    pat = 8'h05;
    for (int b = 7; b >= 0; b--) begin clr(); com(0, 32'h300, 1, pat[b], 32'h400, 0, 0); step(); end
    chk("req026_hold", 64'(spec_hist), 64'hAB);
    clr(); com(0, 32'h300, 1, 1, 32'h400, 0, 0); flush = 1; fetch_valid = 1; pc_start = 32'h300; step();
    chk("req026_flush", 64'(spec_hist), 64'h0B);
    // mispredict counter
    clr(); reset = 1; step();
    repeat (3) begin clr(); commit_valid = 2'b11; commit_mispred = 2'b11; step(); end
    chk("req027_count", 64'(mispred_count), 64'd6);
    clr(); reset = 1; commit_valid = 2'b11; commit_mispred = 2'b11; step();
    chk("req027_reset", 64'(mispred_count), 64'd0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clr();
      reset = $urandom_range(0, 299) == 0;
      fetch_valid = $urandom_range(0, 3) != 0;
      fetch_stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 19) == 0;
      pc_start = $urandom_range(0, 7) == 0 ? ($urandom & ~32'h3) : pool[$urandom_range(0, 5)];
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 1))
          com(l, pool[$urandom_range(0, 5)] + 4 * $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom & ~32'h3,
              $urandom_range(0, 1) ? 8'(spec) : 8'($urandom), $urandom_range(0, 3) == 0);
      step();
    end
    clr();
    repeat (2) @(negedge clock);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
